// File: rtl/simd_ex_stage.sv
// rtl/simd_ex_stage.sv - SIMD execute stage: operand forwarding, per-lane ALU, multi-cycle bytewise GF(2^8) multiply.
// Single-cycle ops load at the accepting edge; GFMUL runs 8 shift-and-add iterations on captured operands.
module simd_ex_stage #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [LANES*LANE_W-1:0] data1,
  input  logic [LANES*LANE_W-1:0] data2,
  input  logic [LANES*LANE_W-1:0] fw1,
  input  logic [LANES*LANE_W-1:0] fw2,
  input  logic [LANES*LANE_W-1:0] fw3,
  input  logic [LANE_W-1:0]       imm,
  input  logic [1:0]              sel_fw_a,
  input  logic [1:0]              sel_fw_b,
  input  logic                    alu_src,
  input  logic [2:0]              alu_op,
  output logic                    busy,
  output logic                    out_valid,
  output logic [LANES*LANE_W-1:0] alu_result,
  output logic [LANES*LANE_W-1:0] write_data
);

  localparam int W    = LANES * LANE_W;
  localparam int NB   = W / 8;
  localparam int SH_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ROTL = 3'b101;
  localparam logic [2:0] OP_GF   = 3'b110;

  logic [W-1:0] op_a, op_fb, op_b, alu_d;
  logic [W-1:0] res_q, wd_q;
  logic [W-1:0] ga_q, gb_q, gp_q, gfb_q;
  logic [W-1:0] ga_d, gb_d, gp_d;
  logic [2:0]   cnt_q;
  logic         busy_q, done_q, valid_q;
  logic         accept;

  always_comb begin
    case (sel_fw_a)
      2'd0:    op_a = data1;
      2'd1:    op_a = fw1;
      2'd2:    op_a = fw2;
      default: op_a = fw3;
    endcase
    case (sel_fw_b)
      2'd0:    op_fb = data2;
      2'd1:    op_fb = fw1;
      2'd2:    op_fb = fw2;
      default: op_fb = fw3;
    endcase
    op_b = alu_src ? {LANES{imm}} : op_fb;
  end

  // Rotate via a doubled word so a zero amount needs no special case.
  always_comb begin
    logic [LANE_W-1:0]   a, b;
    logic [2*LANE_W-1:0] rot;
    alu_d = '0;
    a     = '0;
    b     = '0;
    rot   = '0;
    for (int i = 0; i < LANES; i++) begin
      a   = op_a[i*LANE_W +: LANE_W];
      b   = op_b[i*LANE_W +: LANE_W];
      rot = {a, a} << b[SH_W-1:0];
      case (alu_op)
        OP_ADD:  alu_d[i*LANE_W +: LANE_W] = a + b;
        OP_SUB:  alu_d[i*LANE_W +: LANE_W] = a - b;
        OP_AND:  alu_d[i*LANE_W +: LANE_W] = a & b;
        OP_OR:   alu_d[i*LANE_W +: LANE_W] = a | b;
        OP_XOR:  alu_d[i*LANE_W +: LANE_W] = a ^ b;
        OP_ROTL: alu_d[i*LANE_W +: LANE_W] = rot[2*LANE_W-1 -: LANE_W];
        default: alu_d[i*LANE_W +: LANE_W] = '0;
      endcase
    end
  end

  // One shift-and-add step per byte: accumulate A if B's LSB is set, A <<= 1 mod 0x11B, B >>= 1.
  always_comb begin
    logic [7:0] a8;
    ga_d = ga_q;
    gb_d = gb_q;
    gp_d = gp_q;
    a8   = '0;
    for (int j = 0; j < NB; j++) begin
      a8 = ga_q[j*8 +: 8];
      gp_d[j*8 +: 8] = gp_q[j*8 +: 8] ^ (gb_q[j*8] ? a8 : 8'h00);
      ga_d[j*8 +: 8] = {a8[6:0], 1'b0} ^ (a8[7] ? 8'h1B : 8'h00);
      gb_d[j*8 +: 8] = {1'b0, gb_q[j*8+1 +: 7]};
    end
  end

  assign accept = in_valid & ~stall & ~busy_q & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      wd_q    <= '0;
      ga_q    <= '0;
      gb_q    <= '0;
      gp_q    <= '0;
      gfb_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (!stall) valid_q <= 1'b0;
      if (busy_q) begin
        if (done_q) begin
          // Product finished under stall; release on the first unstalled edge.
          if (!stall) begin
            res_q   <= gp_q;
            wd_q    <= gfb_q;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end else begin
          ga_q  <= ga_d;
          gb_q  <= gb_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7 && !stall) begin
            res_q   <= gp_d;
            wd_q    <= gfb_q;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            gp_q <= gp_d;
            if (cnt_q == 3'd7) done_q <= 1'b1;
          end
        end
      end else if (accept) begin
        if (alu_op == OP_GF) begin
          ga_q   <= op_a;
          gb_q   <= op_b;
          gp_q   <= '0;
          gfb_q  <= op_fb;
          cnt_q  <= '0;
          busy_q <= 1'b1;
        end else begin
          res_q   <= alu_d;
          wd_q    <= op_fb;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign out_valid  = valid_q;
  assign alu_result = res_q;
  assign write_data = wd_q;

endmodule

// File: tb/tb_simd_ex_stage.sv
// tb/tb_simd_ex_stage.sv - scoreboard bench for simd_ex_stage against a transaction-level reference model.
module tb_simd_ex_stage;
  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int W      = LANES * LANE_W;

  logic          clk = 1'b0;
  logic          rst, in_valid, stall, flush, alu_src;
  logic [W-1:0]  data1, data2, fw1, fw2, fw3;
  logic [31:0]   imm;
  logic [1:0]    sel_fw_a, sel_fw_b;
  logic [2:0]    alu_op;
  logic          busy, out_valid;
  logic [W-1:0]  alu_result, write_data;

  simd_ex_stage #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .data1(data1), .data2(data2), .fw1(fw1), .fw2(fw2), .fw3(fw3), .imm(imm),
    .sel_fw_a(sel_fw_a), .sel_fw_b(sel_fw_b), .alu_src(alu_src), .alu_op(alu_op),
    .busy(busy), .out_valid(out_valid), .alu_result(alu_result), .write_data(write_data)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] wd;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: what the stage should show after each edge.
  bit           m_busy  = 0;
  bit           m_valid = 0;
  bit           m_fresh = 0;
  int           m_edges = 0;
  logic [W-1:0] m_res   = '0;
  logic [W-1:0] m_wd    = '0;
  logic [W-1:0] g_res   = '0;
  logic [W-1:0] g_wd    = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Carry-less product then reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p, ax;
    p  = '0;
    ax = {7'b0, a};
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (ax << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] d);
    case (s)
      2'd0:    return d;
      2'd1:    return fw1;
      2'd2:    return fw2;
      default: return fw3;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] r;
    logic [31:0]  a, b, x;
    int           s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      a = av[i*32 +: 32];
      b = bv[i*32 +: 32];
      s = int'(b % 32);
      case (op)
        3'd0: x = a + b;
        3'd1: x = a - b;
        3'd2: x = a & b;
        3'd3: x = a | b;
        3'd4: x = a ^ b;
        3'd5: x = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
        3'd6: for (int j = 0; j < 4; j++) x[j*8 +: 8] = gmul8(a[j*8 +: 8], b[j*8 +: 8]);
        default: x = '0;
      endcase
      r[i*32 +: 32] = x;
    end
    return r;
  endfunction

  task automatic model_edge();
    logic [W-1:0] a, fb, b;
    exp_t e;
    m_fresh = 0;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_res = '0; m_wd = '0;
      exp_q.delete();
    end else if (flush) begin
      m_busy = 0; m_valid = 0;
    end else if (m_busy) begin
      m_edges++;
      if (m_edges >= 8 && !stall) begin
        m_busy = 0; m_valid = 1; m_fresh = 1; m_res = g_res; m_wd = g_wd;
        e.res = g_res; e.wd = g_wd; exp_q.push_back(e);
      end else if (!stall) m_valid = 0;
    end else if (in_valid && !stall) begin
      a  = pick(sel_fw_a, data1);
      fb = pick(sel_fw_b, data2);
      b  = alu_src ? {LANES{imm}} : fb;
      if (alu_op == 3'd6) begin
        m_busy = 1; m_edges = 0; m_valid = 0;
        g_res = ref_alu(alu_op, a, b); g_wd = fb;
      end else begin
        m_valid = 1; m_fresh = 1; m_res = ref_alu(alu_op, a, b); m_wd = fb;
        e.res = m_res; e.wd = m_wd; exp_q.push_back(e);
      end
    end else if (!stall) m_valid = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    data1 = {$urandom, $urandom, $urandom, $urandom};
    data2 = {$urandom, $urandom, $urandom, $urandom};
    fw1   = {$urandom, $urandom, $urandom, $urandom};
    fw2   = {$urandom, $urandom, $urandom, $urandom};
    fw3   = {$urandom, $urandom, $urandom, $urandom};
    imm   = $urandom;
    sel_fw_a = 2'($urandom_range(0, 3));
    sel_fw_b = 2'($urandom_range(0, 3));
    alu_src  = 1'($urandom_range(0, 1));
    alu_op   = 3'($urandom_range(0, 7));
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0; rst = 0;
  endtask

  task automatic issue_gf();
    data1 = {16{8'h57}}; data2 = {16{8'h83}};
    sel_fw_a = 0; sel_fw_b = 0; alu_src = 0; alu_op = 3'd6; in_valid = 1;
    cycle();
  endtask

  task automatic issue_xor();
    rand_inputs(); alu_op = 3'd4; in_valid = 1;
    cycle();
    idle(); cycle();
  endtask

  // Monitor: pops the scoreboard whenever a fresh result should be presented.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy", W'(busy), W'(m_busy));
      chk("out_valid", W'(out_valid), W'(m_valid));
      if (m_fresh) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL scoreboard_empty actual=out_valid%0b expected=queued_entry t=%0t", out_valid, $time);
        end else begin
          e = exp_q.pop_front();
          chk("alu_result", alu_result, e.res);
          chk("write_data", write_data, e.wd);
        end
      end else begin
        chk("alu_result_retained", alu_result, m_res);
        chk("write_data_retained", write_data, m_wd);
      end
    end
  end

  initial begin
    rand_inputs();
    idle();
    rst = 1;
    cycle(); cycle();
    idle(); cycle();

    // Forwarded ADD
    data1 = {4{32'd5}}; fw2 = {4{32'h10}}; data2 = {4{32'd3}};
    sel_fw_a = 2; sel_fw_b = 0; alu_src = 0; alu_op = 3'd0; in_valid = 1;
    cycle();
    idle(); cycle();

    // Immediate SUB
    data1 = '0; sel_fw_a = 0; imm = 32'hFFFF_FFFF; alu_src = 1;
    data2 = {4{32'd7}}; sel_fw_b = 0; alu_op = 3'd1; in_valid = 1;
    cycle();
    idle(); cycle();

    // GFMUL with in_valid pulses while busy
    issue_gf();
    for (int i = 0; i < 10; i++) begin
      rand_inputs(); in_valid = 1'(i % 2);
      cycle();
    end
    idle(); cycle();

    // Stall holds an ADD result, then the next op lands on the first free edge
    rand_inputs(); alu_op = 3'd0; in_valid = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); in_valid = 1; stall = 1;
      cycle();
    end
    rand_inputs(); in_valid = 1; stall = 0; alu_op = 3'd3;
    cycle();
    idle(); cycle();

    // GFMUL completing under stall
    issue_gf();
    idle(); stall = 1;
    for (int i = 0; i < 10; i++) cycle();
    stall = 0; cycle(); cycle();

    // Flush, then reset, on the 3rd busy cycle
    issue_gf();
    idle(); cycle(); cycle();
    flush = 1; cycle();
    idle(); issue_xor();
    issue_gf();
    idle(); cycle(); cycle();
    rst = 1; stall = 1; in_valid = 1; cycle();
    idle(); issue_xor();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      cycle();
    end
    idle(); cycle(); cycle();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/simd_ex_stage.md
SIMD_EX_STAGE -- requirements
Module: simd_ex_stage

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent SIMD lanes (>=1).
REQ-002 SHALL have parameter LANE_W, default 32, lane width in bits (a multiple of 8, >=8).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  operands/control valid this cycle.
REQ-006 SHALL have port stall  in  1  downstream hold request.
REQ-007 SHALL have port flush  in  1  kill the in-flight/held operation.
REQ-008 SHALL have ports data1, data2  in  LANES*LANE_W  register-file operands A/B (lane i = bits [i*LANE_W +: LANE_W]).
REQ-009 SHALL have ports fw1, fw2, fw3  in  LANES*LANE_W  forwarding sources.
REQ-010 SHALL have port imm  in  LANE_W  immediate, broadcast to every lane.
REQ-011 SHALL have ports sel_fw_a, sel_fw_b  in  2  operand select: 0=dataN, 1=fw1, 2=fw2, 3=fw3.
REQ-012 SHALL have port alu_src  in  1  0: ALU B = forwarded B; 1: ALU B = imm.
REQ-013 SHALL have port alu_op  in  3  operation code (REQ-018).
REQ-014 SHALL have port busy  out  1  multi-cycle op in progress; new operations not accepted.
REQ-015 SHALL have port out_valid  out  1  alu_result/write_data hold a valid result.
REQ-016 SHALL have ports alu_result, write_data  out  LANES*LANE_W  registered result / registered forwarded B.

Function
REQ-017 SHALL resolve operands combinationally per lane: A = mux(sel_fw_a), FB = mux(sel_fw_b), B = alu_src ? imm : FB lane.
REQ-018 SHALL implement per lane, modulo 2^LANE_W: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 ROTL A by B[log2(LANE_W)-1:0]; 110 GFMUL; 111 result 0.
REQ-019 SHALL implement GFMUL as bytewise GF(2^8) product of A and B, polynomial 0x11B, byte j of A with byte j of B.
REQ-020 SHALL accept an operation at an edge iff in_valid=1, stall=0, busy=0, flush=0.
REQ-021 SHALL, for accepted single-cycle ops (all except 110), load alu_result and write_data (=FB) at the accepting edge; out_valid=1 after it (latency 1).
REQ-022 SHALL, for accepted GFMUL, capture A, B and FB at the accepting edge, assert busy from the next cycle, run 8 shift-and-add iterations (one per edge), then load the outputs.
REQ-023 SHALL load the GFMUL result at the 8th edge after acceptance if stall=0; busy=0 and out_valid=1 after that edge.
REQ-024 SHALL, if stall=1 when GFMUL iterations are complete, hold busy=1 and the computed product until the first edge with stall=0, then load outputs.
REQ-025 SHALL hold alu_result, write_data and out_valid unchanged at any edge with stall=1 and flush=0.
REQ-026 SHALL clear out_valid at any edge with no accept, no GFMUL load, stall=0; alu_result/write_data retain their last values.
REQ-027 SHALL, at an edge with flush=1, clear out_valid, clear busy, abort any GFMUL, and accept nothing; flush overrides stall and in_valid.
REQ-028 SHALL ignore in_valid and all operand inputs while busy=1 (upstream holds; busy acts as stall).
REQ-029 SHALL evaluate operands of in-progress GFMUL only from captured copies; input changes during busy have no effect.

Reset
REQ-030 SHALL, at an edge with rst=1, set out_valid=0, busy=0, alu_result=0, write_data=0, GFMUL state cleared; rst overrides flush, stall, in_valid.
REQ-031 SHALL accept a new operation at the first edge after rst deasserts if REQ-020 holds.

Verification (LANES=4, LANE_W=32)
REQ-032 Forward ADD: data1 lanes=5, fw2 lanes=0x10, sel_fw_a=2, data2 lanes=3, sel_fw_b=0, alu_src=0, op=000, in_valid=1 -> next cycle out_valid=1, alu_result lanes=0x13, write_data lanes=3.
REQ-033 Immediate SUB: A lanes=0, imm=0xFFFFFFFF, alu_src=1, data2 lanes=7, op=001 -> alu_result lanes=0x00000001, write_data lanes=7.
REQ-034 GFMUL: every byte of A=0x57, of B=0x83, op=110 -> busy=1 for 8 cycles, then alu_result lanes=0xC1C1C1C1, out_valid=1; in_valid pulses during busy ignored.
REQ-035 Stall: after an ADD result, stall=1 for 3 cycles with new in_valid ops -> outputs and out_valid=1 unchanged; op accepted on first stall=0 edge.
REQ-036 Flush/reset mid-GFMUL: flush=1 at 3rd busy cycle -> busy=0, out_valid=0 next cycle, subsequent XOR accepted with latency 1; repeat with rst=1 -> all outputs 0.
